up_counter: RTL and testbench

UP_COUNTER -- requirements
Module: up_counter

---
 rtl/up_counter.sv | 99 +++++++++
 tb/tb_up_counter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/up_counter.sv
// Up counter with load, terminal-count, wrap pulse and saturating wrap counter.
// Define UP_COUNTER_ONESHOT_EN to stop at max_val in a DONE state instead of wrapping.
module up_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic [7:0]       wraps,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [7:0]       wraps_q, wraps_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             atMax;
    logic             inDone;

    // ">=" rather than "==" so a max_val lowered below the count still wraps.
    assign atMax  = (count_q >= max_val);
    assign inDone = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        wraps_d = wraps_q;
        done_d  = done_q;
        if (load) begin
            count_d = (load_val > max_val) ? max_val : load_val;
            wraps_d = 8'd0;
            done_d  = 1'b0;
            state_d = en ? RUN : IDLE;
        end else if (inDone) begin
            state_d = DONE;
        end else if (en) begin
            state_d = RUN;
            if (!atMax) begin
                count_d = count_q + 1'b1;
            end else begin
`ifdef UP_COUNTER_ONESHOT_EN
                count_d = max_val;
                state_d = DONE;
                done_d  = 1'b1;
`else
                count_d = '0;
                wrap_d  = 1'b1;
                if (wraps_q != 8'hFF) begin
                    wraps_d = wraps_q + 8'd1;
                end
`endif
            end
        end else begin
            state_d = IDLE;
        end
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            wrap_q  <= 1'b0;
            wraps_q <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            wraps_q <= wraps_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Gated with rst_n so tc cannot glitch high while reset is held.
    assign tc    = rst_n & en & ~load & ~inDone & (count_q == max_val);
    assign count = count_q;
    assign wrap  = wrap_q;
    assign wraps = wraps_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_up_counter.sv
// Self-checking bench for up_counter: directed steps with a queue of expected results.
module tb_up_counter;

    typedef struct packed {
        logic [2:0] count;
        logic       wrap;
        logic [7:0] wraps;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [2:0] load_val;
    logic [2:0] max_val;
    logic [2:0] count;
    logic       tc;
    logic       wrap;
    logic [7:0] wraps;
    logic       busy;
    logic       done;

    exp_t sb[$];
    int   nCompared   = 0;
    int   nMismatched = 0;

    up_counter #(.WIDTH(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .max_val  (max_val),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap),
        .wraps    (wraps),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int c, input int w, input int ws, input int b, input int d);
        exp_t e;
        e.count = 3'(c);
        e.wrap  = 1'(w);
        e.wraps = 8'(ws);
        e.busy  = 1'(b);
        e.done  = 1'(d);
        return e;
    endfunction

    task automatic checkOutput(input string tag);
        exp_t e;
        nCompared++;
        assert (sb.size() != 0) else begin
            nMismatched++;
            $error("[TB] FAIL %s.queue got empty want entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            nCompared++;
            assert (count === e.count) else begin
                nMismatched++;
                $error("[TB] FAIL %s.count got %0d want %0d", tag, count, e.count);
            end
            nCompared++;
            assert (wrap === e.wrap) else begin
                nMismatched++;
                $error("[TB] FAIL %s.wrap got %0b want %0b", tag, wrap, e.wrap);
            end
            nCompared++;
            assert (wraps === e.wraps) else begin
                nMismatched++;
                $error("[TB] FAIL %s.wraps got %0d want %0d", tag, wraps, e.wraps);
            end
            nCompared++;
            assert (busy === e.busy) else begin
                nMismatched++;
                $error("[TB] FAIL %s.busy got %0b want %0b", tag, busy, e.busy);
            end
            nCompared++;
            assert (done === e.done) else begin
                nMismatched++;
                $error("[TB] FAIL %s.done got %0b want %0b", tag, done, e.done);
            end
        end
    endtask

    task automatic checkTc(input string tag, input logic expTc);
        nCompared++;
        assert (tc === expTc) else begin
            nMismatched++;
            $error("[TB] FAIL %s.tc got %0b want %0b", tag, tc, expTc);
        end
    endtask

    // Drives one cycle of inputs, optionally checks tc before the edge, then checks registered outputs.
    task automatic applyStimulus(input string tag, input logic e, input logic l,
                                 input int lv, input int mv, input exp_t ex,
                                 input logic chkTc = 1'b0, input logic expTc = 1'b0);
        en       = e;
        load     = l;
        load_val = 3'(lv);
        max_val  = 3'(mv);
        sb.push_back(ex);
        #1;
        if (chkTc) checkTc(tag, expTc);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        load_val = 3'd0;
        max_val  = 3'd7;
        #2;
        sb.push_back(mk(0, 0, 0, 0, 0));
        checkOutput("reset");
        checkTc("reset", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef UP_COUNTER_ONESHOT_EN
        // Free-running count to 7 and wrap back to 0.
        for (int i = 1; i <= 9; i++) begin
            applyStimulus("count7", 1'b1, 1'b0, 0, 7,
                          mk(i % 8, (i == 8) ? 1 : 0, (i >= 8) ? 1 : 0, 1, 0),
                          1'b1, ((i - 1) % 8 == 7) ? 1'b1 : 1'b0);
        end

        // Load above max_val clamps to max_val and clears wraps.
        applyStimulus("load3", 1'b0, 1'b1, 3, 5, mk(3, 0, 0, 0, 0));
        applyStimulus("loadClamp", 1'b0, 1'b1, 6, 5, mk(5, 0, 0, 0, 0));
        applyStimulus("hold", 1'b0, 1'b0, 0, 5, mk(5, 0, 0, 0, 0), 1'b1, 1'b0);

        // Load wins over increment; tc suppressed while load is high.
        applyStimulus("loadEn", 1'b1, 1'b1, 2, 5, mk(2, 0, 0, 1, 0), 1'b1, 1'b0);
        applyStimulus("inc", 1'b1, 1'b0, 0, 5, mk(3, 0, 0, 1, 0));
        applyStimulus("maxLowered", 1'b1, 1'b0, 0, 2, mk(0, 1, 1, 1, 0));
        applyStimulus("disable", 1'b0, 1'b0, 0, 2, mk(0, 0, 1, 0, 0));

        // max_val of 0: wraps every cycle, wraps saturates at 255.
        applyStimulus("clrWraps", 1'b0, 1'b1, 0, 0, mk(0, 0, 0, 0, 0));
        for (int i = 1; i <= 300; i++) begin
            applyStimulus("max0", 1'b1, 1'b0, 0, 0,
                          mk(0, 1, (i > 255) ? 255 : i, 1, 0));
        end
`else
        applyStimulus("osLoad", 1'b0, 1'b1, 0, 3, mk(0, 0, 0, 0, 0));
        for (int i = 1; i <= 3; i++) begin
            applyStimulus("osCount", 1'b1, 1'b0, 0, 3, mk(i, 0, 0, 1, 0));
        end
        applyStimulus("osDone", 1'b1, 1'b0, 0, 3, mk(3, 0, 0, 0, 1), 1'b1, 1'b1);
        applyStimulus("osStay", 1'b1, 1'b0, 0, 3, mk(3, 0, 0, 0, 1), 1'b1, 1'b0);
        applyStimulus("osReload", 1'b0, 1'b1, 0, 3, mk(0, 0, 0, 0, 0));
`endif

        // Asynchronous reset mid-count.
        applyStimulus("toFour", 1'b1, 1'b1, 4, 7, mk(4, 0, 0, 1, 0));
        #2;
        max_val = 3'd0;
        rst_n   = 1'b0;
        #1;
        sb.push_back(mk(0, 0, 0, 0, 0));
        checkOutput("asyncRst");
        checkTc("asyncRst", 1'b0);
        #2;
        rst_n = 1'b1;
        applyStimulus("postRstIdle", 1'b0, 1'b0, 0, 7, mk(0, 0, 0, 0, 0));
        applyStimulus("postRstInc", 1'b1, 1'b0, 0, 7, mk(1, 0, 0, 1, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
